mode_counter: RTL and testbench

- Parametrised successor to the basic enable counter.
- Adds up/down direction, programmable modulo limit, parallel load, synchronous clear, and wrap-or-saturate mode, with registered event flags.
- General-purpose timing/event counter for datapath and control blocks; single clock domain.

---
 rtl/mode_counter.sv | 118 +++++++++++
 tb/tb_mode_counter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mode_counter.sv
// Up/down modulo counter with parallel load, synchronous clear, wrap-or-saturate
// boundary handling and registered wrap/saturation flags. Optional prescaler: MODE_COUNTER_PRESCALE_EN.
module mode_counter #(
  parameter int                 WIDTH    = 8,
  parameter longint unsigned    MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter int                 PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             wrap_o,
  output logic             sat_o
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);

  if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : gen_max_val_check
    $error("mode_counter: MAX_VAL must lie in 1..2**WIDTH-1");
  end
  if (PRESCALE < 1) begin : gen_prescale_check
    $error("mode_counter: PRESCALE must be at least 1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             step_tick;

`ifdef MODE_COUNTER_PRESCALE_EN
  localparam int PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  logic [PsW-1:0] ps_q, ps_d;

  // A step fires only on the enabled cycle that completes a prescale interval.
  assign step_tick = en && (ps_q == PsLast);

  always_comb begin
    ps_d = ps_q;
    if (clr || load) begin
      ps_d = '0;
    end else if (en) begin
      ps_d = (ps_q == PsLast) ? '0 : ps_q + PsW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end
`else
  assign step_tick = en;
`endif

  // Priority clr > load > step; rst is applied in the register block.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    sat_d   = sat_q;
    if (clr) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MaxV) ? MaxV : load_val;
      sat_d   = 1'b0;
    end else if (step_tick) begin
      if (up) begin
        if (count_q == MaxV) begin
          if (sat_mode) begin
            sat_d = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          if (sat_mode) begin
            sat_d = 1'b1;
          end else begin
            count_d = MaxV;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sat_q   <= sat_d;
    end
  end

  assign count  = count_q;
  assign wrap_o = wrap_q;
  assign sat_o  = sat_q;

endmodule

// File: tb/tb_mode_counter.sv
// Directed self-checking bench for mode_counter (WIDTH=8, MAX_VAL=9, PRESCALE=4).
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       rst, en, clr, load, up, sat_mode;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       wrap_o, sat_o;
  int         checks = 0;
  int         errors = 0;

  mode_counter #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .up(up), .sat_mode(sat_mode), .count(count), .wrap_o(wrap_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic c, input logic l,
                               input logic [7:0] lv, input logic u, input logic s);
    rst = r; en = e; clr = c; load = l; load_val = lv; up = u; sat_mode = s;
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 8'd0, 1, 0);
    repeat (3) tick();
    checkOutput("reset_count", count, 0);
    checkOutput("reset_wrap", wrap_o, 0);
    checkOutput("reset_sat", sat_o, 0);

`ifndef MODE_COUNTER_PRESCALE_EN
    // Wrapping up-count over 25 steps: 1..9,0..9,0..5 with wrap on each 9->0.
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
    for (int i = 1; i <= 25; i++) begin
      tick();
      checkOutput($sformatf("upcount_%0d", i), count, i % 10);
      checkOutput($sformatf("upwrap_%0d", i), wrap_o, (i % 10) == 0);
    end
    checkOutput("upcount_final", count, 5);

    applyStimulus(0, 0, 0, 1, 8'd3, 1, 0);
    tick();
    checkOutput("load3_count", count, 3);

    // Saturating down-count: 2,1,0,0,0 with sat rising on the 4th step.
    applyStimulus(0, 1, 0, 0, 8'd0, 0, 1);
    tick(); checkOutput("down1", count, 2); checkOutput("down1_sat", sat_o, 0);
    tick(); checkOutput("down2", count, 1); checkOutput("down2_sat", sat_o, 0);
    tick(); checkOutput("down3", count, 0); checkOutput("down3_sat", sat_o, 0);
    tick(); checkOutput("down4", count, 0); checkOutput("down4_sat", sat_o, 1);
    checkOutput("down4_wrap", wrap_o, 0);
    tick(); checkOutput("down5", count, 0); checkOutput("down5_sat", sat_o, 1);
    checkOutput("down5_wrap", wrap_o, 0);

    applyStimulus(0, 1, 0, 1, 8'd5, 0, 1);
    tick();
    checkOutput("load5_count", count, 5);
    checkOutput("load5_sat", sat_o, 0);

    applyStimulus(0, 1, 0, 1, 8'd200, 1, 0);
    tick();
    checkOutput("load_clamp", count, 9);

    // Saturate at the top, then a wrap step keeps the sticky sat flag.
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 1);
    tick();
    checkOutput("top_sat_count", count, 9);
    checkOutput("top_sat_flag", sat_o, 1);
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
    tick();
    checkOutput("sticky_count", count, 0);
    checkOutput("sticky_wrap", wrap_o, 1);
    checkOutput("sticky_sat", sat_o, 1);

    applyStimulus(0, 0, 0, 1, 8'd9, 1, 0);
    tick();
    applyStimulus(0, 1, 1, 1, 8'd6, 1, 0);
    tick();
    checkOutput("clr_over_load_count", count, 0);
    checkOutput("clr_over_load_sat", sat_o, 0);

    applyStimulus(0, 1, 0, 0, 8'd0, 0, 0);
    tick();
    checkOutput("down_wrap_count", count, 9);
    checkOutput("down_wrap_flag", wrap_o, 1);
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
    tick();
    checkOutput("up_wrap_count", count, 0);
    checkOutput("up_wrap_flag", wrap_o, 1);
    applyStimulus(0, 0, 0, 0, 8'd0, 1, 0);
    tick();
    checkOutput("hold_count", count, 0);
    checkOutput("hold_wrap", wrap_o, 0);

    applyStimulus(0, 0, 0, 1, 8'd7, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 8'd0, 1, 0);
    tick();
    checkOutput("hold7", count, 7);
    applyStimulus(1, 1, 0, 1, 8'd4, 1, 0);
    tick();
    checkOutput("rst_pri_count", count, 0);
    checkOutput("rst_pri_wrap", wrap_o, 0);
    checkOutput("rst_pri_sat", sat_o, 0);
`else
    // Prescaled count: one step per 4 enabled cycles.
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
    for (int i = 1; i <= 12; i++) begin
      tick();
      checkOutput($sformatf("ps_count_%0d", i), count, i / 4);
    end
    checkOutput("ps_final", count, 3);
    tick(); checkOutput("ps_mid1", count, 3);
    tick(); checkOutput("ps_mid2", count, 3);
    applyStimulus(0, 0, 0, 0, 8'd0, 1, 0);
    tick(); checkOutput("ps_hold1", count, 3);
    tick(); checkOutput("ps_hold2", count, 3);
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
    tick(); checkOutput("ps_mid3", count, 3);
    tick(); checkOutput("ps_step", count, 4);
    applyStimulus(0, 1, 0, 1, 8'd8, 1, 0);
    tick(); checkOutput("ps_load", count, 8);
    applyStimulus(0, 1, 0, 0, 8'd0, 1, 0);
    repeat (3) tick();
    checkOutput("ps_after_load_hold", count, 8);
    tick();
    checkOutput("ps_after_load_step", count, 9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
